dphy_lane_aligner: RTL and testbench

Parametrised per-lane HS byte/word aligner for the CSI-2 D-PHY receive path. It sits between the lane deserialiser and the lane merger. The block searches a two-word history window for the HS sync pattern, with optional single-bit-error tolerance. It locks the bit offset for the rest of the packet and emits aligned words. Status outputs report lock offset, soft sync errors and hunt timeouts.

---
 rtl/dphy_lane_aligner.sv | 139 +++++++++++++
 tb/tb_dphy_lane_aligner.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dphy_lane_aligner.sv
// dphy_lane_aligner
// Per-lane HS word aligner for the D-PHY receive path. It keeps a two-word
// history window and hunts for the HS sync pattern at every bit offset. A
// single-bit error can optionally be tolerated. Once sync is found, the offset
// is frozen until end of packet, and aligned payload words are emitted.
module dphy_lane_aligner #(
  parameter int                WORD_W         = 8,
  parameter int                SYNC_W         = 8,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN   = 8'hB8,
  parameter bit                ALLOW_1BIT_ERR = 1'b1,
  parameter int                TIMEOUT        = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic [WORD_W-1:0]         unaligned_word_i,
  input  logic                      sync_reset_i,
  output logic                      valid_o,
  output logic [WORD_W-1:0]         aligned_word_o,
  output logic                      locked_o,
  output logic [$clog2(WORD_W)-1:0] lock_offset_o,
  output logic                      soft_err_o,
  output logic                      timeout_o
);

  localparam int OFF_W = $clog2(WORD_W);
  localparam logic [15:0] CNT_MAX = 16'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   d1_q, d2_q;
  logic [15:0]         huntCnt_q, huntCnt_d;
  logic [OFF_W-1:0]    lockOffset_q, lockOffset_d;
  logic [WORD_W-1:0]   aligned_q, aligned_d;
  logic                valid_q, valid_d;
  logic                softErr_q, softErr_d;
  logic                timeout_q, timeout_d;

  logic [2*WORD_W-1:0] window;
  logic [SYNC_W-1:0]   cand;
  logic                exactHit, softAny, softHit;
  logic [OFF_W-1:0]    exactOff, softOff;

  // The older word sits in the low half so that bit order is LSB-first in time
  assign window = {d1_q, d2_q};

  // Scan every bit offset and keep the lowest exact and lowest 1-bit-error match
  always_comb begin
    exactHit = 1'b0;
    softAny  = 1'b0;
    exactOff = '0;
    softOff  = '0;
    cand     = '0;
    for (int s = 0; s < WORD_W; s++) begin
      cand = SYNC_W'(window >> s);
      if (!exactHit && (cand == SYNC_PATTERN)) begin
        exactHit = 1'b1;
        exactOff = OFF_W'(s);
      end
      if (!softAny && ($countones(cand ^ SYNC_PATTERN) == 1)) begin
        softAny = 1'b1;
        softOff = OFF_W'(s);
      end
    end
    softHit = ALLOW_1BIT_ERR && softAny && !exactHit;
  end

  // Next-state logic: hunt/lock control, hunt timeout and the aligned output word
  always_comb begin
    state_d      = state_q;
    huntCnt_d    = huntCnt_q;
    lockOffset_d = lockOffset_q;
    softErr_d    = 1'b0;
    timeout_d    = 1'b0;
    aligned_d    = aligned_q;
    valid_d      = 1'b0;

    if (enable_i) begin
      aligned_d = WORD_W'(window >> lockOffset_q);
      valid_d   = (state_q == LOCKED) && !sync_reset_i;
    end

    if (sync_reset_i) begin
      state_d   = HUNT;
      huntCnt_d = '0;
    end else if ((state_q == HUNT) && enable_i) begin
      if (exactHit || softHit) begin
        state_d      = LOCKED;
        lockOffset_d = exactHit ? exactOff : softOff;
        softErr_d    = !exactHit;
        huntCnt_d    = '0;
      end else if (huntCnt_q == CNT_MAX) begin
        timeout_d = 1'b1;
        huntCnt_d = '0;
      end else begin
        huntCnt_d = huntCnt_q + 16'd1;
      end
    end
  end

  // Register the history window, the control state and all outputs
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      d1_q         <= '0;
      d2_q         <= '0;
      state_q      <= HUNT;
      huntCnt_q    <= '0;
      lockOffset_q <= '0;
      aligned_q    <= '0;
      valid_q      <= 1'b0;
      softErr_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      if (enable_i) begin
        d1_q <= unaligned_word_i;
        d2_q <= d1_q;
      end
      state_q      <= state_d;
      huntCnt_q    <= huntCnt_d;
      lockOffset_q <= lockOffset_d;
      aligned_q    <= aligned_d;
      valid_q      <= valid_d;
      softErr_q    <= softErr_d;
      timeout_q    <= timeout_d;
    end
  end

  assign valid_o        = valid_q;
  assign aligned_word_o = aligned_q;
  assign locked_o       = (state_q == LOCKED);
  assign lock_offset_o  = lockOffset_q;
  assign soft_err_o     = softErr_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_dphy_lane_aligner.sv
// tb_dphy_lane_aligner
// Directed bench for the lane aligner. A second instance with single-bit error
// tolerance disabled shares the same stimulus.
module tb_dphy_lane_aligner;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       en = 1'b0;
  logic [7:0] word = 8'h00;
  logic       syncRst = 1'b0;

  logic       valid, locked, softErr, timeout;
  logic [7:0] aligned;
  logic [2:0] lockOff;

  logic       nValid, nLocked, nSoftErr, nTimeout;
  logic [7:0] nAligned;
  logic [2:0] nLockOff;

  int assertCount = 0;
  int failCount   = 0;

  int t3TimeoutStep = 0;
  int t3NoErrLocked = 0;
  int t4Pulses      = 0;
  int t4First       = 0;
  int t4Second      = 0;
  int t4Locked      = 0;

  dphy_lane_aligner dut (
    .clk_i            (clk),
    .rst_i            (rstN),
    .enable_i         (en),
    .unaligned_word_i (word),
    .sync_reset_i     (syncRst),
    .valid_o          (valid),
    .aligned_word_o   (aligned),
    .locked_o         (locked),
    .lock_offset_o    (lockOff),
    .soft_err_o       (softErr),
    .timeout_o        (timeout)
  );

  dphy_lane_aligner #(.ALLOW_1BIT_ERR(1'b0)) dutNoErr (
    .clk_i            (clk),
    .rst_i            (rstN),
    .enable_i         (en),
    .unaligned_word_i (word),
    .sync_reset_i     (syncRst),
    .valid_o          (nValid),
    .aligned_word_o   (nAligned),
    .locked_o         (nLocked),
    .lock_offset_o    (nLockOff),
    .soft_err_o       (nSoftErr),
    .timeout_o        (nTimeout)
  );

  always #5 clk = ~clk;

  // Drive one word and wait until just after the clock edge that consumes it
  task automatic applyStimulus(input logic [7:0] w, input logic e, input logic s);
    word    = w;
    en      = e;
    syncRst = s;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Hold the synchronous reset low across exactly one clock edge
  task automatic applyReset();
    rstN = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0);
    rstN = 1'b1;
  endtask

  // Watch the no-tolerance instance during the soft-sync sequence
  task automatic trackNoErr(input int idx);
    if (nTimeout && t3TimeoutStep == 0) t3TimeoutStep = idx;
    if (nLocked) t3NoErrLocked++;
  endtask

  // Linear directed sequence
  initial begin
    $display("[TB] start");

    applyReset();
    checkOutput("rst_valid", valid, 1'b0);
    checkOutput("rst_locked", locked, 1'b0);
    checkOutput("rst_aligned", aligned, 8'h00);
    checkOutput("rst_offset", lockOff, 3'd0);
    checkOutput("rst_softerr", softErr, 1'b0);
    checkOutput("rst_timeout", timeout, 1'b0);

    // Offset 0: 00 B8 11 22 33
    $display("[TB] test 1: offset 0");
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'hB8, 1'b1, 1'b0);
    applyStimulus(8'h11, 1'b1, 1'b0);
    checkOutput("t1_not_locked_early", locked, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0);
    checkOutput("t1_locked", locked, 1'b1);
    checkOutput("t1_offset", lockOff, 3'd0);
    checkOutput("t1_valid_latency", valid, 1'b0);
    checkOutput("t1_softerr", softErr, 1'b0);
    applyStimulus(8'h33, 1'b1, 1'b0);
    checkOutput("t1_valid0", valid, 1'b1);
    checkOutput("t1_word0", aligned, 8'h11);
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("t1_word1", aligned, 8'h22);
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("t1_word2", aligned, 8'h33);
    checkOutput("t1_softerr_end", softErr, 1'b0);

    // Offset 5: stream {5A,A5,B8} << 5 gives bytes 00 B7 54 0B
    $display("[TB] test 2: offset 5");
    applyReset();
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'hB7, 1'b1, 1'b0);
    checkOutput("t2_not_locked_early", locked, 1'b0);
    applyStimulus(8'h54, 1'b1, 1'b0);
    checkOutput("t2_locked", locked, 1'b1);
    checkOutput("t2_offset", lockOff, 3'd5);
    checkOutput("t2_valid_latency", valid, 1'b0);
    applyStimulus(8'h0B, 1'b1, 1'b0);
    checkOutput("t2_valid0", valid, 1'b1);
    checkOutput("t2_word0", aligned, 8'hA5);
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("t2_valid1", valid, 1'b1);
    checkOutput("t2_word1", aligned, 8'h5A);

    // Soft sync B9 at offset 3: stream {3C,B9} << 3 gives bytes C8 E5 01
    $display("[TB] test 3: soft sync");
    applyReset();
    applyStimulus(8'h00, 1'b1, 1'b0); trackNoErr(1);
    applyStimulus(8'hC8, 1'b1, 1'b0); trackNoErr(2);
    applyStimulus(8'hE5, 1'b1, 1'b0); trackNoErr(3);
    checkOutput("t3_not_locked_early", locked, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0); trackNoErr(4);
    checkOutput("t3_locked", locked, 1'b1);
    checkOutput("t3_offset", lockOff, 3'd3);
    checkOutput("t3_softerr_pulse", softErr, 1'b1);
    applyStimulus(8'h00, 1'b1, 1'b0); trackNoErr(5);
    checkOutput("t3_softerr_drop", softErr, 1'b0);
    checkOutput("t3_valid0", valid, 1'b1);
    checkOutput("t3_word0", aligned, 8'h3C);
    for (int i = 6; i <= 66; i++) begin
      applyStimulus(8'h00, 1'b1, 1'b0);
      trackNoErr(i);
    end
    checkOutput("t3_noerr_never_locked", t3NoErrLocked, 0);
    checkOutput("t3_noerr_timeout_step", t3TimeoutStep, 64);

    // Idle hunt timeout: 130 enabled cycles of 00
    $display("[TB] test 4: timeout");
    applyReset();
    for (int i = 1; i <= 130; i++) begin
      applyStimulus(8'h00, 1'b1, 1'b0);
      if (timeout) begin
        t4Pulses++;
        if (t4First == 0) t4First = i;
        else if (t4Second == 0) t4Second = i;
      end
      if (locked) t4Locked++;
    end
    checkOutput("t4_pulse_count", t4Pulses, 2);
    checkOutput("t4_first_pulse", t4First, 64);
    checkOutput("t4_second_pulse", t4Second, 128);
    checkOutput("t4_never_locked", t4Locked, 0);

    // Lock at offset 2 ({77,B8} << 2 = E0 DE 01), drop it, then check sync_reset priority
    $display("[TB] test 5: re-lock");
    applyReset();
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'hE0, 1'b1, 1'b0);
    applyStimulus(8'hDE, 1'b1, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0);
    checkOutput("t5_offset2", lockOff, 3'd2);
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("t5_word_off2", aligned, 8'h77);
    applyStimulus(8'hB8, 1'b1, 1'b1);
    checkOutput("t5_unlocked", locked, 1'b0);
    checkOutput("t5_valid_drop", valid, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("t5_hunt_before_hit", locked, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b1);
    checkOutput("t5_syncrst_beats_hit", locked, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("t5_still_hunt", locked, 1'b0);
    applyStimulus(8'hEE, 1'b1, 1'b0);
    applyStimulus(8'h30, 1'b1, 1'b0);
    checkOutput("t5_relocked", locked, 1'b1);
    checkOutput("t5_offset6", lockOff, 3'd6);
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("t5_valid_off6", valid, 1'b1);
    checkOutput("t5_word_off6", aligned, 8'hC3);

    // Reset while locked at offset 6, then enable gaps and a mid-packet reset
    $display("[TB] test 6: enable gaps and mid-packet reset");
    applyReset();
    checkOutput("t6_rst_offset", lockOff, 3'd0);
    checkOutput("t6_rst_aligned", aligned, 8'h00);
    checkOutput("t6_rst_locked", locked, 1'b0);
    applyStimulus(8'hB8, 1'b1, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0);
    applyStimulus(8'h02, 1'b1, 1'b0);
    checkOutput("t6_locked", locked, 1'b1);
    checkOutput("t6_offset", lockOff, 3'd0);
    applyStimulus(8'hFF, 1'b0, 1'b0);
    checkOutput("t6_gap0_valid", valid, 1'b0);
    applyStimulus(8'h03, 1'b1, 1'b0);
    checkOutput("t6_valid0", valid, 1'b1);
    checkOutput("t6_word0", aligned, 8'h01);
    applyStimulus(8'hFF, 1'b0, 1'b0);
    checkOutput("t6_gap1_valid", valid, 1'b0);
    checkOutput("t6_gap1_hold", aligned, 8'h01);
    applyStimulus(8'h04, 1'b1, 1'b0);
    checkOutput("t6_word1", aligned, 8'h02);
    applyStimulus(8'hFF, 1'b0, 1'b0);
    applyStimulus(8'h05, 1'b1, 1'b0);
    checkOutput("t6_word2", aligned, 8'h03);
    checkOutput("t6_valid2", valid, 1'b1);
    rstN = 1'b0;
    applyStimulus(8'h06, 1'b1, 1'b0);
    rstN = 1'b1;
    checkOutput("t6_mid_rst_locked", locked, 1'b0);
    checkOutput("t6_mid_rst_valid", valid, 1'b0);
    checkOutput("t6_mid_rst_aligned", aligned, 8'h00);
    checkOutput("t6_mid_rst_softerr", softErr, 1'b0);
    checkOutput("t6_mid_rst_timeout", timeout, 1'b0);
    applyStimulus(8'h07, 1'b1, 1'b0);
    checkOutput("t6_post_rst_hunt", locked, 1'b0);
    checkOutput("t6_post_rst_valid", valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
